// File: rtl/instr_load_ctrl_if.sv
// Bundled host, cache-write, fetch and status signals of the instruction load controller.
// master = controller side, slave = host/cache/fetch environment side.
interface instr_load_ctrl_if #(
  parameter int unsigned PCW    = 32,
  parameter int unsigned INSTRW = 16,
  parameter int unsigned INW    = 512,
  parameter int unsigned LENW   = 16
);
  logic              load_req;
  logic [LENW-1:0]   load_len;
  logic [PCW-1:0]    load_base;
  logic              abort;
  logic              host_valid;
  logic [INW-1:0]    host_data;
  logic              host_ready;
  logic              cache_wr_en;
  logic [INW-1:0]    cache_wr_data;
  logic [PCW-1:0]    cache_wr_addr;
  logic              fetch_stall;
  logic              fetch_branch;
  logic [PCW-1:0]    fetch_branch_pc;
  logic              fetch_valid;
  logic [INSTRW-1:0] fetch_instr;
  logic              busy;
  logic              done;
  logic [LENW-1:0]   line_cnt;
  logic [31:0]       run_cycles;

  modport master (
    input  load_req, load_len, load_base, abort, host_valid, host_data,
           fetch_valid, fetch_instr,
    output host_ready, cache_wr_en, cache_wr_data, cache_wr_addr,
           fetch_stall, fetch_branch, fetch_branch_pc, busy, done,
           line_cnt, run_cycles
  );

  modport slave (
    output load_req, load_len, load_base, abort, host_valid, host_data,
           fetch_valid, fetch_instr,
    input  host_ready, cache_wr_en, cache_wr_data, cache_wr_addr,
           fetch_stall, fetch_branch, fetch_branch_pc, busy, done,
           line_cnt, run_cycles
  );
endinterface

// File: rtl/instr_load_ctrl.sv
// Fetch-stage sequencer: streams program lines into the instruction cache, launches
// fetch at the base PC, and watches for the halt opcode while counting run cycles.
module instr_load_ctrl #(
  parameter int unsigned PCW    = 32,
  parameter int unsigned INSTRW = 16,
  parameter int unsigned INW    = 512,
  parameter int unsigned LENW   = 16
) (
  input  logic clk,
  input  logic rst,
  instr_load_ctrl_if.master bus
);
  localparam int unsigned IPL = INW / INSTRW;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [PCW-1:0]   base_q;
  logic [PCW-1:0]   addr_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  cnt_q;
  logic [31:0]      cyc_q;
  logic             wr_en_q;
  logic [INW-1:0]   wr_data_q;
  logic [PCW-1:0]   wr_addr_q;
  logic             hs;
  logic             last_line;
  logic             halt;

  assign hs        = (state == LOAD) && bus.host_valid && !bus.abort;
  assign last_line = (cnt_q + LENW'(1)) == len_q;
  assign halt      = bus.fetch_valid && ((bus.fetch_instr >> (INSTRW - 5)) == INSTRW'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.load_req) state_nxt = (bus.load_len == '0) ? START : LOAD;
        LOAD:    if (hs && last_line) state_nxt = START;
        START:   state_nxt = RUN;
        RUN:     if (halt) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // abort forces the stall on combinationally, so fetch never sees the aborted cycle.
  always_comb begin
    bus.host_ready      = (state == LOAD) && !bus.abort;
    bus.fetch_branch    = (state == START) && !bus.abort;
    bus.fetch_branch_pc = '0;
    if ((state == START) && !bus.abort) bus.fetch_branch_pc = base_q;
    bus.fetch_stall     = !(((state == START) || (state == RUN)) && !bus.abort);
    bus.busy            = (state != IDLE);
    bus.done            = (state == DONE);
  end

  // Line address tracked as a running sum (base + n*IPL) rather than a multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      cyc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= hs;
      if (hs) begin
        wr_data_q <= bus.host_data;
        wr_addr_q <= addr_q;
        addr_q    <= addr_q + PCW'(IPL);
        cnt_q     <= cnt_q + LENW'(1);
      end
      if (state == IDLE && bus.load_req) begin
        base_q <= bus.load_base;
        addr_q <= bus.load_base;
        len_q  <= bus.load_len;
        cnt_q  <= '0;
        cyc_q  <= '0;
      end
      if (state == RUN && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
    end
  end

  assign bus.cache_wr_en   = wr_en_q;
  assign bus.cache_wr_data = wr_data_q;
  assign bus.cache_wr_addr = wr_addr_q;
  assign bus.line_cnt      = cnt_q;
  assign bus.run_cycles    = cyc_q;
endmodule
